mux8_stream_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8:1 32-bit select path between eight valid/ready input streams in a CGRA processing element.
- Drives a 3-bit select internally and presents the chosen word on a single registered valid/ready output.
- Also supports a static-route mode, where a configuration select pins the route to one input, matching fixed CGRA routing.

---
 rtl/mux8_stream_arbiter.sv | 96 +++++++++
 tb/tb_mux8_stream_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mux8_stream_arbiter.sv
// Eight-input valid/ready arbiter for a CGRA processing element.
// Round-robin mode rotates the grant over all valid inputs. Static mode
// pins the route to cfg_sel. The chosen word lands in a single registered
// output stage with no skid buffer, giving one word per cycle.
module mux8_stream_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_mode,
  input  logic [2:0]         cfg_sel,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_src,
  input  logic               out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [2:0]       out_src_q;
  logic [2:0]       rr_ptr_q;

  logic             cand_found;
  logic [2:0]       cand_idx;
  logic [2:0]       search_idx;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] sel_word;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // Pick the candidate: first valid input from rr_ptr upward, or cfg_sel when static.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = rr_ptr_q;
    search_idx = '0;
    if (cfg_mode) begin
      for (int k = 0; k < 8; k++) begin
        search_idx = rr_ptr_q + 3'(k);
        if (!cand_found && in_valid[search_idx]) begin
          cand_found = 1'b1;
          cand_idx   = search_idx;
        end
      end
    end else begin
      cand_idx   = cfg_sel;
      cand_found = in_valid[cfg_sel];
    end
  end

  // Grant the candidate only when the output stage can take a word; reset blocks any handshake.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    xfer     = cand_found && can_load && !reset;
    in_ready = '0;
    if (xfer) begin
      in_ready[cand_idx] = 1'b1;
    end
  end

  // Data mux feeding the output register only; in_data never reaches an output combinationally.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) == cand_idx) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_word;
      out_src_q   <= cand_idx;
      // Static grants leave the pointer parked so round-robin resumes where it left off.
      if (cfg_mode) begin
        rr_ptr_q <= cand_idx + 3'd1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8_stream_arbiter.sv
// Directed bench for mux8_stream_arbiter: a table of per-cycle vectors
// followed by hand-written backpressure and mid-stream reset sequences.
module tb_mux8_stream_arbiter;

  localparam int unsigned WIDTH = 32;

  logic               clock;
  logic               reset;
  logic               cfg_mode;
  logic [2:0]         cfg_sel;
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_src;
  logic               out_ready;

  int errors = 0;
  int checks = 0;

  mux8_stream_arbiter #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_mode  (cfg_mode),
    .cfg_sel   (cfg_sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  valid;
    logic        ordy;
    logic [7:0]  exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic [2:0]  exp_src;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic mode, input logic [2:0] sel,
                     input logic [7:0] valid, input logic ordy, input logic [7:0] exp_rdy,
                     input logic exp_ov, input logic [31:0] exp_od, input logic [2:0] exp_src);
    vec_t v;
    v.rst = rst; v.mode = mode; v.sel = sel; v.valid = valid; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_od = exp_od; v.exp_src = exp_src;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: check in_ready before the edge, registered outputs after it.
  task automatic apply(input string tag, input logic rst, input logic mode,
                       input logic [2:0] sel, input logic [7:0] valid, input logic ordy,
                       input logic [7:0] exp_rdy, input logic exp_ov,
                       input logic [31:0] exp_od, input logic [2:0] exp_src);
    reset     = rst;
    cfg_mode  = mode;
    cfg_sel   = sel;
    in_valid  = valid;
    out_ready = ordy;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clock);
    #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'(exp_ov));
    check({tag, " out_data"}, out_data, exp_od);
    check({tag, " out_src"}, 32'(out_src), 32'(exp_src));
  endtask

  initial begin
    reset = 1'b1; cfg_mode = 1'b1; cfg_sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = 32'h100 + 32'(i);

    // Reset for two cycles with every input valid.
    add(1, 1, 0, 8'hFF, 1, 8'h00, 0, 32'h0, 0);
    add(1, 1, 0, 8'hFF, 1, 8'h00, 0, 32'h0, 0);
    // Full round-robin 0..7 then wrap to 0.
    for (int k = 0; k < 8; k++)
      add(0, 1, 0, 8'hFF, 1, 8'h01 << k, 1, 32'h100 + 32'(k), 3'(k));
    add(0, 1, 0, 8'hFF, 1, 8'h01, 1, 32'h100, 0);
    // Continue to a last grant of 5, leaving rr_ptr at 6.
    for (int k = 1; k < 6; k++)
      add(0, 1, 0, 8'hFF, 1, 8'h01 << k, 1, 32'h100 + 32'(k), 3'(k));
    // Wrap fairness: 6 first, then 2.
    add(0, 1, 0, 8'h44, 1, 8'h40, 1, 32'h106, 6);
    add(0, 1, 0, 8'h44, 1, 8'h04, 1, 32'h102, 2);
    // Static route to input 4; rr_ptr stays at 3.
    for (int k = 0; k < 3; k++)
      add(0, 0, 4, 8'hFF, 1, 8'h10, 1, 32'h104, 4);
    // Back to round-robin resumes from 3.
    add(0, 1, 0, 8'hFF, 1, 8'h08, 1, 32'h103, 3);
    // Drain with nothing valid: data/src hold.
    add(0, 1, 0, 8'h00, 1, 8'h00, 0, 32'h103, 3);
    add(0, 1, 0, 8'h00, 0, 8'h00, 0, 32'h103, 3);
    // Static select of an idle input grants nothing.
    add(0, 0, 5, 8'hDF, 1, 8'h00, 0, 32'h103, 3);

    foreach (vecs[n]) begin
      apply($sformatf("vec%0d", n), vecs[n].rst, vecs[n].mode, vecs[n].sel, vecs[n].valid,
            vecs[n].ordy, vecs[n].exp_rdy, vecs[n].exp_ov, vecs[n].exp_od, vecs[n].exp_src);
    end

    // Backpressure: hold DEADBEEF from input 3 for four cycles (rr_ptr is 4).
    in_data[3*WIDTH +: WIDTH] = 32'hDEADBEEF;
    apply("bp_load", 0, 0, 3, 8'hFF, 1, 8'h08, 1, 32'hDEADBEEF, 3);
    for (int c = 0; c < 4; c++)
      apply($sformatf("bp_hold%0d", c), 0, 1, 0, 8'hFF, 0, 8'h00, 1, 32'hDEADBEEF, 3);
    // Drain and reload in the same cycle.
    apply("bp_release", 0, 1, 0, 8'hFF, 1, 8'h10, 1, 32'h104, 4);

    // Reset mid-stream with a pending transfer from input 2.
    in_data[2*WIDTH +: WIDTH] = 32'hCAFE0002;
    apply("rst_mid", 1, 0, 2, 8'h04, 1, 8'h00, 0, 32'h0, 0);
    apply("rst_after0", 0, 1, 0, 8'hFF, 1, 8'h01, 1, 32'h100, 0);
    apply("rst_after2", 0, 1, 0, 8'h04, 1, 8'h04, 1, 32'hCAFE0002, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
